div_op_sequencer: RTL and testbench
===================================

// Module: div_op_sequencer
// PURPOSE
//  Sequences the divider core from the 65-bit input FIFO. Pops two words per operation
//  (dividend first, divisor second), launches the divider, waits for completion, then
//  pushes quotient then remainder to the output stream. Handles divide-by-zero locally
//  and aborts hung divisions with a watchdog.
// PARAMETERS
//  DATA_WIDTH   65   operand/result width (bit DATA_WIDTH-1 = sign)
//  TIMEOUT_CYC  128  max cycles from div_start_o to div_done_i before abort (>=2)
//  CNT_W        8    watchdog counter width; must satisfy 2**CNT_W > TIMEOUT_CYC
// PORTS
//  clk           in   1           clock, rising edge
//  rst_n         in   1           asynchronous reset, active low
//  in_valid_i    in   1           input FIFO holds a word
//  in_data_i     in   DATA_WIDTH  input FIFO head word
//  in_ready_o    out  1           pop strobe to input FIFO (pop when in_valid_i & in_ready_o)
//  div_start_o   out  1           one-cycle launch pulse to divider
//  div_dvd_o     out  DATA_WIDTH  registered dividend, stable from start until done/abort
//  div_dvs_o     out  DATA_WIDTH  registered divisor, same stability
//  div_done_i    in   1           one-cycle completion pulse from divider
//  div_quot_i    in   DATA_WIDTH  quotient, valid with div_done_i
//  div_rem_i     in   DATA_WIDTH  remainder, valid with div_done_i
//  out_valid_o   out  1           result word available
//  out_data_o    out  DATA_WIDTH  result word (quotient, then remainder)
//  out_ready_i   in   1           downstream accepts (transfer when valid & ready)
//  err_div0_o    out  1           one-cycle pulse: divisor was zero
//  err_tmo_o     out  1           one-cycle pulse: watchdog abort
//  busy_o        out  1           high in any state other than IDLE
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; operand/result regs 0; watchdog 0.
//  States: IDLE -> GET_A -> GET_B -> LAUNCH -> WAIT -> OUT_Q -> OUT_R -> IDLE.
//  IDLE: leaves to GET_A next cycle unconditionally when in_valid_i=1, else holds.
//  GET_A/GET_B: in_ready_o=1 combinationally in these states only; on handshake capture
//   word into div_dvd_o / div_dvs_o and advance. No handshake -> hold, no timeout here.
//  GET_B exit: if captured divisor==0 -> skip divider: quotient reg = all ones,
//   remainder reg = dividend, err_div0_o pulses next cycle, go OUT_Q. Else go LAUNCH.
//  LAUNCH: div_start_o=1 for exactly this cycle; watchdog cleared; go WAIT.
//  WAIT: watchdog increments each cycle. div_done_i=1 -> capture quot/rem, go OUT_Q.
//   Watchdog reaches TIMEOUT_CYC with no done -> err_tmo_o pulse, results discarded,
//   go IDLE (no output words). div_done_i in the same cycle as expiry wins (results kept).
//   div_done_i outside WAIT is ignored.
//  OUT_Q/OUT_R: out_valid_o=1, out_data_o = quotient / remainder register; holds value
//   and valid until out_ready_i; advance on handshake. OUT_R handshake -> IDLE.
//  Throughput: min 6 cycles per op plus divider latency; back-to-back ops need IDLE cycle.
//  Outputs registered except in_ready_o (state decode). out_data_o never changes while
//   out_valid_o=1 and out_ready_i=0.
//  Reset mid-operation: immediate return to IDLE, all outputs 0; partially popped pair
//   is lost (FIFO is reset by the same rst_n).
// TESTING
//  1. Push 100, 7, divider returns q=14 r=2 after 10 cycles -> div_start_o one pulse,
//     div_dvd_o=100, div_dvs_o=7; out words 14 then 2; busy_o low afterwards.
//  2. Push -100 (65-bit two's comp), 0 -> no div_start_o; err_div0_o 1 pulse; outputs
//     0x1_FFFF_FFFF_FFFF_FFFF then -100.
//  3. out_ready_i held low 20 cycles in OUT_Q -> out_valid_o and out_data_o stable;
//     release -> quotient then remainder delivered exactly once each.
//  4. Divider never answers -> err_tmo_o pulses TIMEOUT_CYC=128 cycles after start,
//     no out_valid_o, next pushed pair processed normally.
//  5. in_valid_i drops between dividend and divisor for 5 cycles -> sequencer holds in
//     GET_B, in_ready_o=1, correct pairing when divisor arrives.
//  6. Assert rst_n=0 during WAIT -> all outputs 0 asynchronously; after release a
//     fresh pair 9,3 yields 3,0.

Source files
------------

// File: rtl/div_op_sequencer_if.sv
// Handshake and data bundle between the divide-op sequencer and its FIFO, divider and sink.
// The slave modport is the sequencer's view; master is the surrounding environment.
interface div_op_sequencer_if #(
  parameter int unsigned DATA_WIDTH = 65
);
  logic                  in_valid_i;
  logic [DATA_WIDTH-1:0] in_data_i;
  logic                  in_ready_o;
  logic                  div_start_o;
  logic [DATA_WIDTH-1:0] div_dvd_o;
  logic [DATA_WIDTH-1:0] div_dvs_o;
  logic                  div_done_i;
  logic [DATA_WIDTH-1:0] div_quot_i;
  logic [DATA_WIDTH-1:0] div_rem_i;
  logic                  out_valid_o;
  logic [DATA_WIDTH-1:0] out_data_o;
  logic                  out_ready_i;
  logic                  err_div0_o;
  logic                  err_tmo_o;
  logic                  busy_o;

  modport slave (
    input  in_valid_i, in_data_i, div_done_i, div_quot_i, div_rem_i, out_ready_i,
    output in_ready_o, div_start_o, div_dvd_o, div_dvs_o, out_valid_o, out_data_o,
           err_div0_o, err_tmo_o, busy_o
  );

  modport master (
    output in_valid_i, in_data_i, div_done_i, div_quot_i, div_rem_i, out_ready_i,
    input  in_ready_o, div_start_o, div_dvd_o, div_dvs_o, out_valid_o, out_data_o,
           err_div0_o, err_tmo_o, busy_o
  );
endinterface

// File: rtl/div_op_sequencer.sv
// Pops dividend/divisor pairs, drives the divider with a watchdog, and streams quotient
// then remainder; divide-by-zero is answered locally without launching the divider.
module div_op_sequencer #(
  parameter int unsigned DATA_WIDTH  = 65,
  parameter int unsigned TIMEOUT_CYC = 128,
  parameter int unsigned CNT_W       = 8
) (
  input logic               clk,
  input logic               rst_n,
  div_op_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_GET_A, S_GET_B, S_LAUNCH, S_WAIT, S_OUT_Q, S_OUT_R
  } state_e;

  localparam logic [CNT_W-1:0] WDOG_LIMIT = CNT_W'(TIMEOUT_CYC);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] dvd_q, dvd_d;
  logic [DATA_WIDTH-1:0] dvs_q, dvs_d;
  logic [DATA_WIDTH-1:0] rem_q, rem_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_valid_q, out_valid_d;
  logic                  start_q, start_d;
  logic                  div0_q, div0_d;
  logic                  tmo_q, tmo_d;
  logic                  busy_q, busy_d;
  logic [CNT_W-1:0]      wdog_q, wdog_d;
  logic [CNT_W-1:0]      wdog_inc;

  assign wdog_inc = wdog_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    rem_d       = rem_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    wdog_d      = wdog_q;
    start_d     = 1'b0;
    div0_d      = 1'b0;
    tmo_d       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.in_valid_i) state_d = S_GET_A;
      end
      S_GET_A: begin
        if (bus.in_valid_i) begin
          dvd_d   = bus.in_data_i;
          state_d = S_GET_B;
        end
      end
      S_GET_B: begin
        if (bus.in_valid_i) begin
          dvs_d = bus.in_data_i;
          if (bus.in_data_i == '0) begin
            out_data_d  = '1;
            rem_d       = dvd_q;
            out_valid_d = 1'b1;
            div0_d      = 1'b1;
            state_d     = S_OUT_Q;
          end else begin
            start_d = 1'b1;
            wdog_d  = '0;
            state_d = S_LAUNCH;
          end
        end
      end
      // Watchdog holds the cycle count since the start pulse, so the abort pulse
      // lands exactly TIMEOUT_CYC cycles after div_start_o.
      S_LAUNCH: begin
        wdog_d  = wdog_inc;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        wdog_d = wdog_inc;
        if (bus.div_done_i) begin
          out_data_d  = bus.div_quot_i;
          rem_d       = bus.div_rem_i;
          out_valid_d = 1'b1;
          state_d     = S_OUT_Q;
        end else if (wdog_inc == WDOG_LIMIT) begin
          tmo_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_OUT_Q: begin
        if (bus.out_ready_i) begin
          out_data_d = rem_q;
          state_d    = S_OUT_R;
        end
      end
      S_OUT_R: begin
        if (bus.out_ready_i) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      dvd_q       <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      start_q     <= 1'b0;
      div0_q      <= 1'b0;
      tmo_q       <= 1'b0;
      busy_q      <= 1'b0;
      wdog_q      <= '0;
    end else begin
      state_q     <= state_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      rem_q       <= rem_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      start_q     <= start_d;
      div0_q      <= div0_d;
      tmo_q       <= tmo_d;
      busy_q      <= busy_d;
      wdog_q      <= wdog_d;
    end
  end

  assign bus.in_ready_o  = (state_q == S_GET_A) || (state_q == S_GET_B);
  assign bus.div_start_o = start_q;
  assign bus.div_dvd_o   = dvd_q;
  assign bus.div_dvs_o   = dvs_q;
  assign bus.out_valid_o = out_valid_q;
  assign bus.out_data_o  = out_data_q;
  assign bus.err_div0_o  = div0_q;
  assign bus.err_tmo_o   = tmo_q;
  assign bus.busy_o      = busy_q;

endmodule

// File: tb/tb_div_op_sequencer.sv
// Scoreboard bench for div_op_sequencer: stimulus queues expected operands and result
// words, a monitor pops and compares whenever the DUT launches or emits a word.
module tb_div_op_sequencer;
  localparam int unsigned DW  = 65;
  localparam int unsigned TMO = 128;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  div_op_sequencer_if #(.DATA_WIDTH(DW)) bus ();

  div_op_sequencer #(.DATA_WIDTH(DW), .TIMEOUT_CYC(TMO), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_fail = 0;
  logic [DW-1:0] exp_out[$];
  logic [DW-1:0] exp_dvd[$];
  logic [DW-1:0] exp_dvs[$];

  // divider model controls
  bit            resp_en = 1'b1;
  int            lat = 10;
  logic [DW-1:0] mq = '0;
  logic [DW-1:0] mr = '0;

  // monitor event counters
  int n_start = 0;
  int n_div0 = 0;
  int n_tmo = 0;
  int cyc = 0;
  int start_cyc = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // Divider model: answers a start pulse with mq/mr after lat cycles.
  initial begin
    bus.div_done_i = 1'b0;
    bus.div_quot_i = '0;
    bus.div_rem_i  = '0;
    forever begin
      @(negedge clk);
      if (rst_n && bus.div_start_o && resp_en) begin
        repeat (lat) @(posedge clk);
        #1;
        bus.div_done_i = 1'b1;
        bus.div_quot_i = mq;
        bus.div_rem_i  = mr;
        @(posedge clk);
        #1;
        bus.div_done_i = 1'b0;
      end
    end
  end

  // Monitor / scoreboard
  initial begin
    logic          p_start, p_div0, p_tmo, p_valid, p_ready;
    logic [DW-1:0] p_data, e;
    p_start = 0; p_div0 = 0; p_tmo = 0; p_valid = 0; p_ready = 0; p_data = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        p_start = 0; p_div0 = 0; p_tmo = 0; p_valid = 0; p_ready = 0;
        continue;
      end
      if (bus.div_start_o) begin
        n_start++;
        start_cyc = cyc;
        chk("start_width", p_start, 1'b0);
        if (exp_dvd.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_start: dvd %h dvs %h", bus.div_dvd_o, bus.div_dvs_o);
        end else begin
          chk("div_dvd", bus.div_dvd_o, exp_dvd.pop_front());
          chk("div_dvs", bus.div_dvs_o, exp_dvs.pop_front());
        end
      end
      if (bus.err_div0_o) begin
        n_div0++;
        chk("div0_width", p_div0, 1'b0);
      end
      if (bus.err_tmo_o) begin
        n_tmo++;
        chk("tmo_width", p_tmo, 1'b0);
        chk("tmo_latency", DW'(cyc - start_cyc), DW'(TMO));
      end
      if (p_valid && !p_ready) begin
        chk("hold_valid", bus.out_valid_o, 1'b1);
        chk("hold_data", bus.out_data_o, p_data);
      end
      if (bus.out_valid_o && bus.out_ready_i) begin
        if (exp_out.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_out: got %h expected no word", bus.out_data_o);
        end else begin
          e = exp_out.pop_front();
          chk("out_word", bus.out_data_o, e);
        end
      end
      p_start = bus.div_start_o;
      p_div0  = bus.err_div0_o;
      p_tmo   = bus.err_tmo_o;
      p_valid = bus.out_valid_o;
      p_ready = bus.out_ready_i;
      p_data  = bus.out_data_o;
    end
  end

  task automatic push_word(input logic [DW-1:0] w);
    bit ok;
    ok = 0;
    @(posedge clk);
    #1;
    bus.in_valid_i = 1'b1;
    bus.in_data_i  = w;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.in_ready_o) begin
        ok = 1;
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.in_valid_i = 1'b0;
    if (!ok) bound_fail("push_word");
  endtask

  task automatic wait_idle(input int limit);
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (!bus.busy_o && exp_out.size() == 0) return;
    end
    bound_fail("wait_idle");
  endtask

  task automatic op(input logic [DW-1:0] a, input logic [DW-1:0] b,
                    input logic [DW-1:0] q, input logic [DW-1:0] r, input int l);
    lat = l; mq = q; mr = r;
    exp_dvd.push_back(a);
    exp_dvs.push_back(b);
    exp_out.push_back(q);
    exp_out.push_back(r);
    push_word(a);
    push_word(b);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"},      bus.busy_o,      1'b0);
    chk({tag, "_in_ready"},  bus.in_ready_o,  1'b0);
    chk({tag, "_start"},     bus.div_start_o, 1'b0);
    chk({tag, "_dvd"},       bus.div_dvd_o,   '0);
    chk({tag, "_dvs"},       bus.div_dvs_o,   '0);
    chk({tag, "_out_valid"}, bus.out_valid_o, 1'b0);
    chk({tag, "_out_data"},  bus.out_data_o,  '0);
    chk({tag, "_err_div0"},  bus.err_div0_o,  1'b0);
    chk({tag, "_err_tmo"},   bus.err_tmo_o,   1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "global timeout");
  end

  initial begin
    int s0, d0, t0;
    logic [DW-1:0] neg100;
    bus.in_valid_i  = 1'b0;
    bus.in_data_i   = '0;
    bus.out_ready_i = 1'b1;
    neg100 = DW'(-100);

    #12;
    check_zero("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // 1: basic op
    s0 = n_start;
    op(DW'(100), DW'(7), DW'(14), DW'(2), 10);
    wait_idle(100);
    repeat (2) @(negedge clk);
    chk("t1_starts", DW'(n_start - s0), DW'(1));
    chk("t1_busy_after", bus.busy_o, 1'b0);
    chk("t1_valid_after", bus.out_valid_o, 1'b0);

    // 2: divide by zero
    s0 = n_start; d0 = n_div0;
    exp_out.push_back({DW{1'b1}});
    exp_out.push_back(neg100);
    push_word(neg100);
    push_word('0);
    wait_idle(100);
    chk("t2_starts", DW'(n_start - s0), DW'(0));
    chk("t2_div0", DW'(n_div0 - d0), DW'(1));

    // 3: downstream backpressure in OUT_Q
    bus.out_ready_i = 1'b0;
    op(DW'(50), DW'(6), DW'(8), DW'(2), 3);
    begin
      bit seen;
      seen = 0;
      for (int i = 0; i < 50; i++) begin
        @(negedge clk);
        if (bus.out_valid_o) begin seen = 1; break; end
      end
      if (!seen) bound_fail("t3_out_valid");
    end
    repeat (20) @(posedge clk);
    #1 bus.out_ready_i = 1'b1;
    wait_idle(100);
    repeat (3) @(negedge clk);
    chk("t3_drained", DW'(exp_out.size()), DW'(0));

    // 4: divider never answers, then a normal op
    t0 = n_tmo;
    resp_en = 1'b0;
    exp_dvd.push_back(DW'(10));
    exp_dvs.push_back(DW'(2));
    push_word(DW'(10));
    push_word(DW'(2));
    wait_idle(400);
    chk("t4_tmo", DW'(n_tmo - t0), DW'(1));
    resp_en = 1'b1;
    op(DW'(20), DW'(4), DW'(5), DW'(0), 6);
    wait_idle(100);

    // Watchdog boundary: answer one cycle before expiry is kept, at expiry is lost.
    t0 = n_tmo;
    op(DW'(1000), DW'(10), DW'(100), DW'(0), TMO - 1);
    wait_idle(400);
    chk("bnd_keep_tmo", DW'(n_tmo - t0), DW'(0));
    lat = TMO; mq = DW'(3); mr = DW'(1);
    exp_dvd.push_back(DW'(10));
    exp_dvs.push_back(DW'(3));
    push_word(DW'(10));
    push_word(DW'(3));
    wait_idle(400);
    repeat (4) @(negedge clk);
    chk("bnd_late_tmo", DW'(n_tmo - t0), DW'(1));

    // 5: gap between dividend and divisor
    push_word(DW'(77));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t5_getb_ready", bus.in_ready_o, 1'b1);
    end
    lat = 4; mq = DW'(7); mr = DW'(0);
    exp_dvd.push_back(DW'(77));
    exp_dvs.push_back(DW'(11));
    exp_out.push_back(DW'(7));
    exp_out.push_back(DW'(0));
    push_word(DW'(11));
    wait_idle(100);

    // 6: reset during WAIT
    s0 = n_start;
    resp_en = 1'b0;
    exp_dvd.push_back(DW'(30));
    exp_dvs.push_back(DW'(5));
    push_word(DW'(30));
    push_word(DW'(5));
    for (int i = 0; i < 20 && n_start == s0; i++) @(negedge clk);
    if (n_start == s0) bound_fail("t6_start");
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_zero("midreset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    resp_en = 1'b1;
    repeat (2) @(posedge clk);
    op(DW'(9), DW'(3), DW'(3), DW'(0), 4);
    wait_idle(100);
    repeat (3) @(negedge clk);
    chk("final_out_queue", DW'(exp_out.size()), DW'(0));
    chk("final_op_queue", DW'(exp_dvd.size()), DW'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
